// File: rtl/axi_lite_mem_slave_if.sv
// rtl/axi_lite_mem_slave_if.sv - AXI-lite channel bundle between a bus master port and the memory responder
interface axi_lite_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8:0]   s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [RESP_WIDTH-1:0]   s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [RESP_WIDTH-1:0]   s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI-lite responder backed by a word-addressed register memory
// Define AXI_MEM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of wrapping the index.
module axi_lite_mem_slave #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int          RESP_WIDTH = 3,
    parameter int          MEM_DEPTH  = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    axi_lite_mem_slave_if.slave s_axi
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W     = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]            w_state_q, w_state_d;
    logic [0:0]            r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [BYTES-1:0]      wstrb_q,   wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q,   bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [BYTES-1:0]      c_strb;
    logic [ADDR_WIDTH-1:0] c_offset;
    logic [IDX_W-1:0]      c_idx;
    logic                  c_ok;
    logic [ADDR_WIDTH-1:0] r_offset;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_ok;

    logic                  unused_wstrb_msb;
    assign unused_wstrb_msb = s_axi.s_axi_wstrb[BYTES];

    function automatic logic [ADDR_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] addr);
        return addr - BASE;
    endfunction

    // The modulo only matters when the index wraps; in range it is the plain word number.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] offset);
        return IDX_W'((offset >> LSB) % DEPTH_W);
    endfunction

`ifdef AXI_MEM_SLVERR_EN
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] offset);
        return 64'(offset) < (64'(MEM_DEPTH) * 64'(BYTES));
    endfunction
`endif

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_d     = mem_q;
        commit    = 1'b0;
        c_addr    = awaddr_q;
        c_data    = wdata_q;
        c_strb    = wstrb_q;

        case (w_state_q)
            W_IDLE: begin
                if (s_axi.s_axi_awvalid && awready_q && s_axi.s_axi_wvalid && wready_q) begin
                    commit = 1'b1;
                    c_addr = s_axi.s_axi_awaddr;
                    c_data = s_axi.s_axi_wdata;
                    c_strb = s_axi.s_axi_wstrb[BYTES-1:0];
                end else if (s_axi.s_axi_awvalid && awready_q) begin
                    awaddr_d  = s_axi.s_axi_awaddr;
                    w_state_d = W_HAVE_ADDR;
                end else if (s_axi.s_axi_wvalid && wready_q) begin
                    wdata_d   = s_axi.s_axi_wdata;
                    wstrb_d   = s_axi.s_axi_wstrb[BYTES-1:0];
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (s_axi.s_axi_wvalid && wready_q) begin
                    commit = 1'b1;
                    c_data = s_axi.s_axi_wdata;
                    c_strb = s_axi.s_axi_wstrb[BYTES-1:0];
                end
            end
            W_HAVE_DATA: begin
                if (s_axi.s_axi_awvalid && awready_q) begin
                    commit = 1'b1;
                    c_addr = s_axi.s_axi_awaddr;
                end
            end
            W_RESP: begin
                if (s_axi.s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        c_offset = addr_offset(c_addr);
        c_idx    = word_index(c_offset);
        c_ok     = 1'b1;
`ifdef AXI_MEM_SLVERR_EN
        c_ok     = addr_in_range(c_offset);
`endif

        if (commit) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = c_ok ? RESP_OKAY : RESP_SLVERR;
            if (c_ok) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (c_strb[b]) begin
                        mem_d[c_idx][8*b +: 8] = c_data[8*b +: 8];
                    end
                end
            end
        end

        // Readies are registered, so they follow the state being entered.
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_offset  = addr_offset(s_axi.s_axi_araddr);
        r_idx     = word_index(r_offset);
        r_ok      = 1'b1;
`ifdef AXI_MEM_SLVERR_EN
        r_ok      = addr_in_range(r_offset);
`endif

        case (r_state_q)
            R_IDLE: begin
                if (s_axi.s_axi_arvalid && arready_q) begin
                    // mem_q is the pre-edge contents, so a same-edge write is not visible here.
                    rdata_d   = r_ok ? mem_q[r_idx] : '0;
                    rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            mem_q     <= '{default: '0};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            mem_q     <= mem_d;
        end
    end

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

endmodule
